// File: rtl/icb_slave_pkg.sv
// Shared types and constants for the ICB register/SRAM slave.
package icb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    RSP      = 2'd3
  } icb_state_e;

  localparam int REG_CTRL_IDX     = 0;
  localparam int DEF_NUM_REGS     = 4;
  localparam int DEF_SRAM_AW      = 13;
  localparam int DEF_SRAM_SEL_BIT = 16;
  localparam int DEF_SRAM_RD_LAT  = 1;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/icb_regfile.sv
// Byte-masked config register file; register 0 writes also fire a one-cycle ctrl pulse.
module icb_regfile
  import icb_slave_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [3:0]               wr_idx,
  input  logic [31:0]              wr_data,
  input  logic [3:0]               wr_mask,
  output logic [NUM_REGS-1:0][31:0] regs,
  output logic [15:0]              ctrl_pulse
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs       <= '0;
      ctrl_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_en && wr_idx == 4'(i)) regs[i] <= merge_bytes(regs[i], wr_data, wr_mask);
      // pulse honours the byte mask just like the stored copy
      ctrl_pulse <= (wr_en && wr_idx == 4'(REG_CTRL_IDX)) ?
                    (wr_data[15:0] & {{8{wr_mask[1]}}, {8{wr_mask[0]}}}) : 16'h0;
    end
  end

endmodule

// File: rtl/icb_slave_mp.sv
// ICB slave: register window plus SRAM window with configurable read latency.
// Define ICB_SLAVE_ERR_EN to flag unmapped / empty-mask accesses with icb_rsp_err.
module icb_slave_mp
  import icb_slave_pkg::*;
#(
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int SRAM_AW      = DEF_SRAM_AW,
  parameter int SRAM_DEPTH   = 2**SRAM_AW,
  parameter int SRAM_SEL_BIT = DEF_SRAM_SEL_BIT,
  parameter int SRAM_RD_LAT  = DEF_SRAM_RD_LAT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   icb_cmd_valid,
  output logic                   icb_cmd_ready,
  input  logic                   icb_cmd_read,
  input  logic [31:0]            icb_cmd_addr,
  input  logic [31:0]            icb_cmd_wdata,
  input  logic [3:0]             icb_cmd_wmask,
  output logic                   icb_rsp_valid,
  input  logic                   icb_rsp_ready,
  output logic [31:0]            icb_rsp_rdata,
  output logic                   icb_rsp_err,
  output logic [NUM_REGS*32-1:0] cfg_regs,
  output logic [15:0]            ctrl_pulse,
  input  logic [15:0]            status_in,
  output logic                   sram_wr_en,
  output logic [SRAM_AW-1:0]     sram_wr_addr,
  output logic [31:0]            sram_wr_data,
  output logic [3:0]             sram_wr_be,
  output logic                   sram_rd_en,
  output logic [SRAM_AW-1:0]     sram_rd_addr,
  input  logic [31:0]            sram_rd_data
);

  icb_state_e               state, state_nxt;
  logic [NUM_REGS-1:0][31:0] regs;
  logic [SRAM_AW-1:0]       sram_waddr, rd_addr_q;
  logic [3:0]               reg_idx;
  logic [1:0]               rd_cnt;
  logic [31:0]              reg_rdata;
  logic accept, sram_win, reg_hit, sram_hit, cmd_err, rd_done;
  logic do_reg_wr, do_sram_wr, do_sram_rd;
  logic unused_addr;

  assign icb_cmd_ready = rst_n && (state == IDLE);
  assign icb_rsp_valid = (state == RSP);
  assign accept        = icb_cmd_valid && icb_cmd_ready;
  assign sram_win      = icb_cmd_addr[SRAM_SEL_BIT];
  assign reg_idx       = icb_cmd_addr[5:2];
  assign sram_waddr    = icb_cmd_addr[SRAM_AW+1:2];
  assign reg_hit       = 32'(reg_idx) < 32'(NUM_REGS);
  assign sram_hit      = 32'(sram_waddr) < 32'(SRAM_DEPTH);
  assign unused_addr   = ^icb_cmd_addr;
  assign rd_done       = rd_cnt == 2'(SRAM_RD_LAT - 1);

`ifdef ICB_SLAVE_ERR_EN
  assign cmd_err = !(sram_win ? sram_hit : reg_hit) || (!icb_cmd_read && icb_cmd_wmask == 4'h0);
`else
  assign cmd_err = 1'b0;
`endif

  assign do_reg_wr  = accept && !icb_cmd_read && !sram_win && reg_hit && !cmd_err;
  assign do_sram_wr = accept && !icb_cmd_read &&  sram_win && sram_hit && !cmd_err;
  assign do_sram_rd = accept &&  icb_cmd_read &&  sram_win && sram_hit && !cmd_err;

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (reg_idx == 4'(i)) reg_rdata = (i == REG_CTRL_IDX) ? {status_in, 16'h0} : regs[i];
  end

  icb_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (do_reg_wr),
    .wr_idx     (reg_idx),
    .wr_data    (icb_cmd_wdata),
    .wr_mask    (icb_cmd_wmask),
    .regs       (regs),
    .ctrl_pulse (ctrl_pulse)
  );
  assign cfg_regs = regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = do_sram_rd ? RD_ISSUE : RSP;
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  if (rd_done) state_nxt = RSP;
      RSP:      if (icb_rsp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign sram_rd_en   = (state == RD_ISSUE);
  assign sram_rd_addr = sram_rd_en ? rd_addr_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icb_rsp_rdata <= '0;
      icb_rsp_err   <= 1'b0;
      rd_cnt        <= '0;
      rd_addr_q     <= '0;
      sram_wr_en    <= 1'b0;
      sram_wr_addr  <= '0;
      sram_wr_data  <= '0;
      sram_wr_be    <= '0;
    end else begin
      sram_wr_en   <= do_sram_wr;
      sram_wr_addr <= do_sram_wr ? sram_waddr    : '0;
      sram_wr_data <= do_sram_wr ? icb_cmd_wdata : '0;
      sram_wr_be   <= do_sram_wr ? icb_cmd_wmask : '0;
      if (accept) begin
        icb_rsp_err   <= cmd_err;
        // SRAM reads overwrite this once the data arrives
        icb_rsp_rdata <= (icb_cmd_read && !sram_win && !cmd_err) ? reg_rdata : '0;
      end
      if (do_sram_rd) rd_addr_q <= sram_waddr;
      if (state == RD_ISSUE)     rd_cnt <= '0;
      else if (state == RD_WAIT) rd_cnt <= rd_cnt + 2'd1;
      if (state == RD_WAIT && rd_done) icb_rsp_rdata <= sram_rd_data;
    end
  end

endmodule

// File: doc/icb_slave_mp.md
ICB_SLAVE_MP -- requirements
Module: icb_slave_mp

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of 32-bit register words (2..16).
REQ-002 SHALL have parameter SRAM_AW, default 13, SRAM word-address width.
REQ-003 SHALL have parameter SRAM_DEPTH, default 2**SRAM_AW, number of mapped SRAM words.
REQ-004 SHALL have parameter SRAM_SEL_BIT, default 16, address bit selecting the SRAM window (1) or the register window (0).
REQ-005 SHALL have parameter SRAM_RD_LAT, default 1, SRAM read latency in cycles (1..4).
REQ-006 SHALL have one clock and an asynchronous active-low reset.
REQ-007 SHALL have these ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- icb_cmd_valid/icb_cmd_ready  in/out  1  command handshake
- icb_cmd_read  in  1  1 = read
- icb_cmd_addr  in  32  byte address
- icb_cmd_wdata  in  32  write data
- icb_cmd_wmask  in  4  byte enables, 1 = write byte
- icb_rsp_valid/icb_rsp_ready  out/in  1  response handshake
- icb_rsp_rdata  out  32  read data
- icb_rsp_err  out  1  error flag
- cfg_regs  out  NUM_REGS*32  flattened register file, word i at [32i+31:32i]
- ctrl_pulse  out  16  one-cycle write pulses
- status_in  in  16  read-only status
- sram_wr_en/sram_wr_addr/sram_wr_data/sram_wr_be  out  1/SRAM_AW/32/4  SRAM write port
- sram_rd_en/sram_rd_addr  out  1/SRAM_AW  SRAM read request
- sram_rd_data  in  32  valid SRAM_RD_LAT cycles after sram_rd_en

Function
REQ-008 SHALL decode register index as icb_cmd_addr[5:2] and SRAM word address as icb_cmd_addr[SRAM_AW+1:2]; bits [1:0] are ignored.
REQ-009 SHALL use an FSM with states IDLE, RD_ISSUE, RD_WAIT and RSP; icb_cmd_ready = 1 only in IDLE.
REQ-010 SHALL accept a command in cycle A when valid&ready and SHALL move to RSP (writes, register reads) or RD_ISSUE (SRAM reads).
REQ-011 Register write: cfg_regs word updates at A+1, per byte under wmask; icb_rsp_valid = 1 at A+1.
REQ-012 Register 0: bits [15:0] SHALL drive ctrl_pulse for exactly cycle A+1, then return to 0. Reads of register 0 SHALL return {status_in, 16'h0}.
REQ-013 Registers 1..NUM_REGS-1 SHALL be plain read/write.
REQ-014 SRAM write: sram_wr_en = 1 for exactly cycle A+1, with the latched address, data and sram_wr_be = wmask; icb_rsp_valid = 1 at A+1.
REQ-015 Register read: rdata is sampled at A; icb_rsp_valid = 1 at A+1.
REQ-016 SRAM read: sram_rd_en = 1 for exactly cycle A+1 (RD_ISSUE); RD_WAIT counts SRAM_RD_LAT cycles; sram_rd_data is captured at A+1+SRAM_RD_LAT; icb_rsp_valid = 1 at A+2+SRAM_RD_LAT.
REQ-017 In RSP, icb_rsp_valid, rdata and err SHALL hold stable until icb_rsp_ready; on valid&ready the FSM returns to IDLE, giving 1-cycle-gap back-to-back commands.
REQ-018 Write responses SHALL carry icb_rsp_rdata = 0.
REQ-019 sram_* outputs SHALL be 0 whenever not enabled.

Reset
REQ-020 On rst_n low, the FSM SHALL go to IDLE and all outputs and cfg_regs SHALL go to 0, including mid-transaction; an in-flight response SHALL be dropped.
REQ-021 icb_cmd_ready SHALL be 0 during reset and 1 in the first cycle after release.

Configuration
REQ-022 With ICB_SLAVE_ERR_EN defined, these accesses SHALL return icb_rsp_err = 1 and rdata 0, perform no write and issue no SRAM access (register-read timing):
- register index >= NUM_REGS
- SRAM word address >= SRAM_DEPTH
- a write with wmask = 0
REQ-023 Without ICB_SLAVE_ERR_EN:
- icb_rsp_err SHALL be tied 0
- unmapped reads SHALL return 0
- unmapped writes SHALL be dropped
- wmask = 0 writes SHALL complete as no-ops

Structure
REQ-024 Package icb_slave_pkg SHALL hold:
- the FSM state enum
- REG_CTRL_IDX = 0
- default parameter constants
REQ-025 The register storage, byte-mask merge and ctrl_pulse generation SHALL be a sub-module icb_regfile; the ICB FSM and SRAM sequencing stay in icb_slave_mp.

Verification
REQ-026 Write 0x0000_00A5, mask 4'hF, to addr 0x0 -> ctrl_pulse = 0x00A5 for one cycle; a read of 0x0 with status_in = 0x1234 returns 0x1234_0000.
REQ-027 Write 0xDEAD_BEEF, mask 4'b0101, to addr 0x4 (reg1 = 0) -> reg1 = 0x00AD_00EF; rsp_valid at A+1.
REQ-028 Write 0x1111_2222 to addr 0x1_0008, then read it back with SRAM_RD_LAT = 2 -> sram_wr_addr = 2; sram_rd_en at A+1; rdata 0x1111_2222; rsp_valid at A+4.
REQ-029 Hold icb_rsp_ready = 0 for 5 cycles on a read -> rsp_valid, rdata and err stay stable; cmd_ready = 0 throughout.
REQ-030 With ICB_SLAVE_ERR_EN defined and NUM_REGS = 4, write addr 0x10 -> rsp_err = 1 and no cfg_regs change; without the macro -> rsp_err = 0.
REQ-031 Assert rst_n low during RD_WAIT -> all outputs 0; cmd_ready = 1 the cycle after release; no stale response.
